// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: instruction fields in, stall and forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    input  stall, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    output stall, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers behind decode; produces load-use stall,
// registered forwarding selects for the EX instruction and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  hazard_scoreboard_if.slave sb
);
  localparam int SEL_W = $clog2(DEPTH);
  localparam int R_W   = $clog2(DEPTH + 1);
  // The oldest stage (DEPTH) is never matched, so only stages 1..DEPTH-1 are stored.
  localparam int NT    = DEPTH - 1;

  logic              v_q  [1:NT];
  logic [REG_AW-1:0] rd_q [1:NT];
  logic              wr_q [1:NT];
  logic [R_W-1:0]    r_q  [1:NT];

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic [SEL_W-1:0]  fwd_a_q, fwd_b_q;
  logic              hz_a, hz_b;
  logic              stall, insert;
  logic [CNT_W-1:0]  cnt_q;

  // Returns {hazard, select}; the youngest matching stage wins even if not yet ready.
  function automatic logic [SEL_W:0] lookup(input logic used, input logic [REG_AW-1:0] src);
    logic [SEL_W:0] res;
    logic           found;
    res   = '0;
    found = 1'b0;
    if (used && src != '0) begin
      for (int unsigned p = 1; p < DEPTH; p++) begin
        if (!found && v_q[p] && wr_q[p] && rd_q[p] == src) begin
          found = 1'b1;
          if (r_q[p] <= R_W'(p)) res[SEL_W-1:0] = SEL_W'(p);
          else                   res[SEL_W]     = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {hz_a, sel_a} = lookup(sb.id_rs1_used, sb.id_rs1);
    {hz_b, sel_b} = lookup(sb.id_rs2_used, sb.id_rs2);
    stall  = sb.id_valid && !sb.flush && (hz_a || hz_b);
    insert = sb.id_valid && !stall && !sb.flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 1; p < DEPTH; p++) begin
        v_q[p]  <= 1'b0;
        rd_q[p] <= '0;
        wr_q[p] <= 1'b0;
        r_q[p]  <= '0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else if (enable) begin
      for (int unsigned p = NT; p >= 2; p--) begin
        v_q[p]  <= v_q[p-1];
        rd_q[p] <= rd_q[p-1];
        wr_q[p] <= wr_q[p-1];
        r_q[p]  <= r_q[p-1];
      end
      v_q[1]  <= insert;
      rd_q[1] <= sb.id_rd;
      wr_q[1] <= sb.id_regwrite && (sb.id_rd != '0);
      r_q[1]  <= sb.id_is_load ? R_W'(1 + LOAD_LAT) : R_W'(1);
      fwd_a_q <= insert ? sel_a : '0;
      fwd_b_q <= insert ? sel_b : '0;
      if (stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sb.stall     = stall;
  assign sb.fwd_a     = fwd_a_q;
  assign sb.fwd_b     = fwd_b_q;
  assign sb.stall_cnt = cnt_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It generalises the fixed two-source forwarding unit to a configurable pipeline depth and load latency, and adds load-use stall detection, flush handling and a stall performance counter. It sits beside the decode stage and tracks every in-flight destination register. It produces a combinational stall for IF/ID and registered forwarding selects aligned to the instruction entering EX.

## Interface
- REG_AW, 5, register-address width.
- DEPTH, 3, tracked stages after decode (EX=1, MEM=2, WB=3). Legal range is 2 or more.
- LOAD_LAT, 1, extra cycles before load data is forwardable. Legal range is 1..DEPTH-1.
- CNT_W, 16, stall counter width.
- SEL_W, clog2(DEPTH), derived width of the forwarding selects.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance. When 0, all state holds.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1 / id_rs2  in  REG_AW  source registers.
- id_rs1_used / id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  redirect taken; the decode instruction is killed.
- stall  out  1  hold PC and IF/ID, and insert a bubble into EX.
- fwd_a / fwd_b  out  SEL_W  operand select for the EX instruction.
  - 0 selects register-file data.
  - j (1..DEPTH-1) selects the pipeline register after stage j.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- **Tracker state.** The tracker holds DEPTH entries {v, rd, wr, r}. Entry p holds the instruction currently in stage p.
  - r is the ready stage: 1 for a non-load, 1+LOAD_LAT for a load.
  - wr = id_regwrite AND (id_rd != 0).
- **Advance.** On each enabled edge, entry p moves to p+1 and entry DEPTH retires. Entry 1 is loaded as follows:
  - With the decode instruction when id_valid AND NOT stall AND NOT flush.
  - Otherwise with a bubble (v=0).
- **Source lookup.** Applies to each source s with s_used=1 and s != 0.
  - Find the smallest p in 1..DEPTH-1 with v AND wr AND rd==s. The youngest match wins, even if an older match is ready.
  - Entry DEPTH is never matched. The register file is write-first, so it supplies that value.
- **Hazard resolution for a match at p.**
  - If r <= p, the operand forwards from the pipeline register after stage p, and the registered select becomes p.
  - If r > p, the operand is hazarded.
  - No match gives select 0.
- **Stall.** stall = id_valid AND NOT flush AND (either source hazarded).
- **Select update.** On each enabled edge, fwd_a and fwd_b load the computed selects when the decode instruction is inserted. Otherwise they load 0.
- **Flush priority.** Flush overrides stall. A bubble is inserted, stall is 0, and the tracked entries still advance.
- **Disabled cycles.** With enable=0, no state, select or counter changes. stall stays combinational but has no effect.
- **Stall counter.** stall_cnt increments on each enabled edge with stall=1. It saturates at 2^CNT_W-1 and never wraps.
- **Reset.** Asserting reset, including mid-operation, asynchronously clears:
  - all v to 0,
  - fwd_a and fwd_b to 0,
  - stall_cnt to 0.
  - stall is therefore 0 immediately.
  - Normal operation resumes from the first edge after reset goes high.

## Timing
- stall is combinational from tracker state and the id_* and flush inputs, valid in the same cycle.
- fwd_a and fwd_b have 1-cycle latency. They are valid during the cycle the consumer occupies EX.
- Load-use penalty is LOAD_LAT cycles for a consumer immediately behind a load. In general it is max(0, r-p) stall cycles.
- Each stall cycle re-evaluates the lookup. The producer advances one stage per enabled cycle, so stall deasserts once r <= p.
- Simultaneous stall and flush: flush wins, and the counter does not increment.
- An enable=0 cycle does not age entries, so the hazard distance is preserved.

## Test plan
All scenarios use DEPTH=3 and LOAD_LAT=1.
- **Reset mid-operation.** Fill the tracker, then pull reset low for 1 cycle.
  - Expect stall=0, fwd_a=fwd_b=0 and stall_cnt=0 asynchronously.
  - After release, the next consumer of an old rd gets fwd=0.
- **ALU forwarding.**
  - add x5 followed by sub x6,x5,x1: stall never asserts and fwd_a=1 in sub's EX cycle.
  - Inserting one nop between them instead gives fwd_a=2.
  - Inserting two nops gives fwd_a=0.
- **Load-use.** lw x7 followed by add x8,x1,x7.
  - Expect stall=1 for exactly 1 cycle and stall_cnt=1.
  - Then fwd_b=2 and fwd_a=0 in add's EX cycle.
- **Youngest wins.** add x3, then lw x3, then use x3: 1 stall cycle, then fwd=2 from the lw. With add x3, add x3, use x3: no stall and fwd=1.
- **x0 and unused sources.**
  - A producer with rd=0 followed by a consumer with rs1=0: no stall, fwd_a=0.
  - lw x9 followed by a consumer with rs2=x9 and rs2_used=0: no stall.
- **Flush, enable and saturation.**
  - A load-use stall cycle with flush=1 gives stall=0, inserts a bubble and leaves stall_cnt unchanged.
  - enable=0 for 3 cycles mid-stall leaves the tracker, selects and counter frozen.
  - Preloading stall_cnt to saturation via repeated stalls with CNT_W=2 holds it at 3.
